port_seq_arbiter: RTL

PORT_SEQ_ARBITER -- requirements
Module: port_seq_arbiter

---
 rtl/port_seq_arbiter.sv | 106 ++++++++++
 1 files changed

// File: rtl/port_seq_arbiter.sv
// Round-robin arbiter that walks the granted port through a three-step sequence
// (STEP0..STEP2), with stall via enable and cancellation when the owner drops req.
module port_seq_arbiter #(
   parameter int unsigned PORTS    = 4,
   parameter int unsigned STEP_LEN = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [PORTS-1:0] req,
   input  logic             enable,
   output logic [PORTS-1:0] grant,
   output logic [1:0]       step,
   output logic             busy,
   output logic [PORTS-1:0] done,
   output logic [PORTS-1:0] abort
);

   localparam int unsigned PW = (PORTS > 1) ? $clog2(PORTS) : 1;
   localparam int unsigned CW = (STEP_LEN > 1) ? $clog2(STEP_LEN) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_STEP0 = 2'd1,
      S_STEP1 = 2'd2,
      S_STEP2 = 2'd3
   } state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [PW-1:0]   rr_ptr;
   logic [PW-1:0]   gidx;
   logic [PW-1:0]   sel_idx;
   logic            sel_found;
   logic [PW-1:0]   next_ptr;
   logic            step_last;

   // Round-robin search starting at rr_ptr, wrapping modulo PORTS
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int unsigned i = 0; i < PORTS; i++) begin
         if (!sel_found && req[PW'((32'(rr_ptr) + i) % PORTS)]) begin
            sel_found = 1'b1;
            sel_idx   = PW'((32'(rr_ptr) + i) % PORTS);
         end
      end
   end

   assign next_ptr  = PW'((32'(gidx) + 32'd1) % PORTS);
   assign step_last = (cnt == CW'(STEP_LEN - 1));
   assign step      = state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= S_IDLE;
         cnt    <= '0;
         rr_ptr <= '0;
         gidx   <= '0;
         grant  <= '0;
         busy   <= 1'b0;
         done   <= '0;
         abort  <= '0;
      end else begin
         done  <= '0;
         abort <= '0;
         case (state)
            S_IDLE: begin
               if (enable && sel_found) begin
                  state <= S_STEP0;
                  gidx  <= sel_idx;
                  grant <= PORTS'(1) << sel_idx;
                  busy  <= 1'b1;
                  cnt   <= '0;
               end
            end
            default: begin
               // Owner dropping req cancels the sequence regardless of enable
               if (!req[gidx]) begin
                  state  <= S_IDLE;
                  abort  <= grant;
                  grant  <= '0;
                  busy   <= 1'b0;
                  rr_ptr <= next_ptr;
                  cnt    <= '0;
               end else if (enable) begin
                  if (step_last) begin
                     cnt <= '0;
                     if (state == S_STEP2) begin
                        state  <= S_IDLE;
                        done   <= grant;
                        grant  <= '0;
                        busy   <= 1'b0;
                        rr_ptr <= next_ptr;
                     end else begin
                        state <= state_t'(state + 2'd1);
                     end
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
            end
         endcase
      end
   end

endmodule
